// File: rtl/pvr_vram_arb.sv
// pvr_vram_arb: round-robin arbiter for the shared PVR VRAM port.
// Serves RA parser (0), ISP (1) and TSP (2); one access in flight.
module pvr_vram_arb #(
    parameter int NREQ    = 3,
    parameter int TIMEOUT = 1023
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NREQ-1:0]    req_rd,
    input  logic [NREQ-1:0]    req_wr,
    input  logic [NREQ*24-1:0] req_addr,
    input  logic [NREQ*32-1:0] req_wdata,
    output logic [NREQ-1:0]    req_wait,
    output logic [NREQ-1:0]    req_valid,
    output logic [31:0]        req_dout,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic [23:0]        mem_addr,
    output logic [31:0]        mem_wdata,
    input  logic               mem_wait,
    input  logic               mem_valid,
    input  logic [31:0]        mem_din,
    output logic [1:0]         grant_id,
    output logic               busy,
    output logic               err_timeout
);

    localparam int GW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW0 = $clog2(TIMEOUT + 1);
    localparam int CW  = (CW0 < 10) ? 10 : CW0;
    // Counter value seen in the TIMEOUT-th DATA cycle without mem_valid.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DATA
    } state_t;

    state_t          state;
    logic [GW-1:0]   grant;
    logic [GW-1:0]   last_grant;
    logic [GW-1:0]   pick;
    logic            found;
    logic            op_wr;
    logic [CW-1:0]   wd_cnt;
    logic [NREQ-1:0] pend;

    assign pend     = req_rd | req_wr;
    assign busy     = (state != IDLE);
    assign grant_id = 2'(grant);

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && pend[(int'(last_grant) + k) % NREQ]) begin
                found = 1'b1;
                pick  = GW'((int'(last_grant) + k) % NREQ);
            end
        end
    end

    // Only the granted requester sees wait drop, and only in its accept cycle.
    always_comb begin
        req_wait = '1;
        if (state == ISSUE && !mem_wait) begin
            req_wait[grant] = 1'b0;
        end
    end

    // Arbitration FSM with registered VRAM strobes, read return and watchdog.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            grant       <= '0;
            last_grant  <= GW'(NREQ - 1);
            op_wr       <= 1'b0;
            wd_cnt      <= '0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            req_valid   <= '0;
            req_dout    <= '0;
            err_timeout <= 1'b0;
        end else begin
            req_valid <= '0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        grant      <= pick;
                        last_grant <= pick;
                        // A write wins; a co-pending read re-arbitrates later.
                        op_wr      <= req_wr[pick];
                        mem_wr     <= req_wr[pick];
                        mem_rd     <= !req_wr[pick];
                        mem_addr   <= req_addr[int'(pick)*24 +: 24];
                        mem_wdata  <= req_wdata[int'(pick)*32 +: 32];
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!mem_wait) begin
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                        wd_cnt <= '0;
                        state  <= op_wr ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (mem_valid) begin
                        req_valid[grant] <= 1'b1;
                        req_dout         <= mem_din;
                        state            <= IDLE;
                    end else if (wd_cnt == CNT_LAST) begin
                        // Lost read data: release the requester with a marker.
                        req_valid[grant] <= 1'b1;
                        req_dout         <= 32'hDEADBEEF;
                        err_timeout      <= 1'b1;
                        state            <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pvr_vram_arb.sv
// tb_pvr_vram_arb: randomized requesters and VRAM against a
// transaction-schedule reference model of the arbiter.
module tb_pvr_vram_arb;

    localparam int NREQ    = 3;
    localparam int TIMEOUT = 1023;

    logic               clock = 1'b0;
    logic               reset_n = 1'b0;
    logic [NREQ-1:0]    req_rd;
    logic [NREQ-1:0]    req_wr;
    logic [NREQ*24-1:0] req_addr;
    logic [NREQ*32-1:0] req_wdata;
    logic [NREQ-1:0]    req_wait;
    logic [NREQ-1:0]    req_valid;
    logic [31:0]        req_dout;
    logic               mem_rd;
    logic               mem_wr;
    logic [23:0]        mem_addr;
    logic [31:0]        mem_wdata;
    logic               mem_wait;
    logic               mem_valid;
    logic [31:0]        mem_din;
    logic [1:0]         grant_id;
    logic               busy;
    logic               err_timeout;

    pvr_vram_arb #(
        .NREQ(NREQ),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .req_rd(req_rd),
        .req_wr(req_wr),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .req_wait(req_wait),
        .req_valid(req_valid),
        .req_dout(req_dout),
        .mem_rd(mem_rd),
        .mem_wr(mem_wr),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wait(mem_wait),
        .mem_valid(mem_valid),
        .mem_din(mem_din),
        .grant_id(grant_id),
        .busy(busy),
        .err_timeout(err_timeout)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Requester agents
    logic        ag_rd[NREQ];
    logic        ag_wr[NREQ];
    logic        awaiting[NREQ];
    logic [23:0] ag_addr[NREQ];
    logic [31:0] ag_wdata[NREQ];

    // Current transaction schedule (cycle numbers)
    bit          cur_on;
    bit          cur_wr;
    bit          cur_drop;
    int          cur_g;
    int          cur_t;
    int          cur_a;
    int          cur_end;
    logic [23:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [31:0] cur_din;
    int          last;

    // Expected registered outputs
    logic [NREQ-1:0] exp_valid;
    logic [31:0]     exp_dout;
    logic [23:0]     exp_maddr;
    logic [31:0]     exp_mwdata;
    int              exp_gid;
    bit              exp_err;

    int stall_max;
    int lat_max;
    int gen_pct;
    bit force_drop;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < NREQ; i++) begin
            req_rd[i]            = ag_rd[i];
            req_wr[i]            = ag_wr[i];
            req_addr[i*24 +: 24] = ag_addr[i];
            req_wdata[i*32 +: 32] = ag_wdata[i];
        end
    endtask

    task automatic model_reset();
        cur_on     = 1'b0;
        last       = NREQ - 1;
        exp_valid  = '0;
        exp_dout   = '0;
        exp_maddr  = '0;
        exp_mwdata = '0;
        exp_gid    = 0;
        exp_err    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            ag_rd[i]    = 1'b0;
            ag_wr[i]    = 1'b0;
            awaiting[i] = 1'b0;
            ag_addr[i]  = '0;
            ag_wdata[i] = '0;
        end
        drive_reqs();
        mem_wait  = 1'b0;
        mem_valid = 1'b0;
        mem_din   = '0;
    endtask

    task automatic check_reset_vals();
        check("rst_wait", 32'(req_wait), 32'h7);
        check("rst_valid", 32'(req_valid), 32'h0);
        check("rst_dout", req_dout, 32'h0);
        check("rst_mem_rd", 32'(mem_rd), 32'h0);
        check("rst_mem_wr", 32'(mem_wr), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_grant", 32'(grant_id), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_err", 32'(err_timeout), 32'h0);
    endtask

    task automatic preset_all_pending();
        for (int i = 0; i < NREQ; i++) begin
            ag_rd[i]    = 1'b1;
            ag_wr[i]    = (i == NREQ - 1);
            ag_addr[i]  = 24'h000100 + 24'(i * 24'h100000);
            ag_wdata[i] = 32'hA5000000 + 32'(i);
        end
    endtask

    task automatic step();
        int g;
        int idx;
        int kind;
        bit strobe;
        logic [NREQ-1:0] exp_wait;
        @(posedge clock);
        #1;
        cyc++;
        // Requester drops its strobe after seeing its accept cycle
        if (cur_on && cyc == cur_a + 1) begin
            if (cur_wr) begin
                ag_wr[cur_g] = 1'b0;
            end else begin
                ag_rd[cur_g]    = 1'b0;
                awaiting[cur_g] = 1'b1;
            end
        end
        // New random requests from idle requesters
        for (int i = 0; i < NREQ; i++) begin
            if (!ag_rd[i] && !ag_wr[i] && !awaiting[i] &&
                int'($urandom_range(0, 99)) < gen_pct) begin
                kind        = int'($urandom_range(0, 2));
                ag_rd[i]    = (kind != 1);
                ag_wr[i]    = (kind != 0);
                ag_addr[i]  = 24'($urandom);
                ag_wdata[i] = $urandom;
            end
        end
        // Completion: read data returned one cycle after the last busy cycle
        exp_valid = '0;
        if (cur_on && cyc == cur_end + 1) begin
            if (!cur_wr) begin
                exp_valid[cur_g] = 1'b1;
                exp_dout         = cur_drop ? 32'hDEADBEEF : cur_din;
                awaiting[cur_g]  = 1'b0;
                if (cur_drop) exp_err = 1'b1;
            end
            cur_on = 1'b0;
        end
        if (cur_on && cyc == cur_t + 1) begin
            exp_gid    = cur_g;
            exp_maddr  = cur_addr;
            exp_mwdata = cur_wdata;
        end
        // Arbitration when the port is free
        if (!cur_on) begin
            g = -1;
            for (int k = 1; k <= NREQ; k++) begin
                idx = (last + k) % NREQ;
                if (g < 0 && (ag_rd[idx] || ag_wr[idx])) g = idx;
            end
            if (g >= 0) begin
                cur_on    = 1'b1;
                cur_g     = g;
                cur_t     = cyc;
                cur_wr    = ag_wr[g];
                cur_addr  = ag_addr[g];
                cur_wdata = ag_wdata[g];
                cur_a     = cyc + 1 + int'($urandom_range(0, stall_max));
                cur_drop  = !cur_wr && force_drop;
                if (cur_drop) force_drop = 1'b0;
                if (cur_wr) cur_end = cur_a;
                else if (cur_drop) cur_end = cur_a + TIMEOUT;
                else cur_end = cur_a + int'($urandom_range(1, lat_max));
                last = g;
            end
        end
        drive_reqs();
        // VRAM side
        if (cur_on && cyc > cur_t && cyc <= cur_a) mem_wait = (cyc < cur_a);
        else mem_wait = ($urandom_range(0, 1) == 1);
        mem_din = $urandom;
        if (cur_on && !cur_wr && cyc > cur_a && cyc <= cur_end) begin
            mem_valid = !cur_drop && (cyc == cur_end);
            if (mem_valid) cur_din = mem_din;
        end else begin
            mem_valid = ($urandom_range(0, 3) == 0);
        end
        @(negedge clock);
        exp_wait = '1;
        if (cur_on && cyc == cur_a) exp_wait[cur_g] = 1'b0;
        strobe = cur_on && cyc > cur_t && cyc <= cur_a;
        check("req_wait", 32'(req_wait), 32'(exp_wait));
        check("req_valid", 32'(req_valid), 32'(exp_valid));
        check("req_dout", req_dout, exp_dout);
        check("mem_rd", 32'(mem_rd), 32'(strobe && !cur_wr));
        check("mem_wr", 32'(mem_wr), 32'(strobe && cur_wr));
        check("mem_addr", 32'(mem_addr), 32'(exp_maddr));
        check("mem_wdata", mem_wdata, exp_mwdata);
        check("busy", 32'(busy),
              32'(cur_on && cyc > cur_t && cyc <= cur_end));
        check("grant_id", 32'(grant_id), 32'(exp_gid));
        check("err_timeout", 32'(err_timeout), 32'(exp_err));
    endtask

    initial begin
        int n;
        model_reset();
        stall_max  = 6;
        lat_max    = 6;
        gen_pct    = 30;
        force_drop = 1'b0;
        reset_n    = 1'b0;
        #12;
        check_reset_vals();
        @(negedge clock);
        reset_n = 1'b1;

        // Simultaneous requests right after reset: order 0,1,2
        preset_all_pending();
        repeat (3000) step();

        // Watchdog on a read that never returns data
        force_drop = 1'b1;
        repeat (1500) step();
        check("err_sticky", 32'(err_timeout), 32'h1);

        // Asynchronous reset while a read waits in DATA
        lat_max   = 40;
        stall_max = 2;
        n = 0;
        while (!(cur_on && !cur_wr && cyc > cur_a && cyc <= cur_end) &&
               n < 500) begin
            step();
            n++;
        end
        check("reach_data", 32'(n >= 500), 32'h0);
        check("data_busy", 32'(busy), 32'h1);
        #2;
        reset_n   = 1'b0;
        mem_valid = 1'b1;
        #1;
        check_reset_vals();
        @(posedge clock);
        #1;
        check_reset_vals();
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        mem_valid = 1'b1;

        // Full contention: rotation 0,1,2 with TSP write before its read
        preset_all_pending();
        stall_max = 3;
        lat_max   = 4;
        gen_pct   = 100;
        repeat (300) step();
        gen_pct   = 30;
        stall_max = 6;
        lat_max   = 6;
        repeat (2000) step();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
